// File: rtl/conv_pkg.sv
// conv_pkg: tile geometry and writer FSM state shared with the convolution datapath
package conv_pkg;
    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int DATA_W = 8;
    localparam int ELEMS  = ROWS * COLS;
    typedef enum logic [1:0] {IDLE, LOAD_FILT, LOAD_IMG, HOLD} state_t;
endpackage

// File: rtl/tile_bank.sv
// tile_bank: ELEMS x DATA_W register bank with indexed write, flat readout and sync clear
module tile_bank #(
    parameter int ELEMS  = 9,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]       wdata,
    output logic [ELEMS*DATA_W-1:0] flat
);
    logic [DATA_W-1:0] mem_q [ELEMS];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ELEMS; e++) mem_q[e] <= '0;
        end else if (we) begin
            mem_q[idx] <= wdata;
        end
    end
    for (genvar e = 0; e < ELEMS; e++) begin : g_flat
        assign flat[e*DATA_W +: DATA_W] = mem_q[e];
    end
endmodule

// File: rtl/conv_tile_writer.sv
// conv_tile_writer: streams a filter tile then an image tile into two banks and holds them until ack.
// Define CONV_TILE_FILTER_REUSE_EN to let a start with load_filter=0 keep an already loaded filter.
module conv_tile_writer #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        load_filter,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [ROWS*COLS*DATA_W-1:0] filter_flat,
    output logic [ROWS*COLS*DATA_W-1:0] img_flat,
    output logic                        tile_valid,
    input  logic                        tile_ack,
    output logic                        busy
);
    import conv_pkg::*;
    localparam int TILE_ELEMS = ROWS * COLS;
    localparam int IDX_W      = $clog2(TILE_ELEMS);
    state_t state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d, idx;
    logic filter_loaded_q, filter_loaded_d;
    logic beat, last, col_wrap, skip;
`ifdef CONV_TILE_FILTER_REUSE_EN
    assign skip = !load_filter && filter_loaded_q;
`else
    logic unused_cfg;
    assign unused_cfg = load_filter ^ filter_loaded_q;
    assign skip = 1'b0;
`endif
    assign s_ready    = state_q == LOAD_FILT || state_q == LOAD_IMG;
    assign tile_valid = state_q == HOLD;
    assign busy       = state_q != IDLE;
    assign beat       = s_valid && s_ready;
    assign col_wrap   = col_q == IDX_W'(COLS - 1);
    assign last       = col_wrap && row_q == IDX_W'(ROWS - 1);
    assign idx        = IDX_W'(row_q * IDX_W'(COLS) + col_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            row_q           <= '0;
            col_q           <= '0;
            filter_loaded_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            filter_loaded_q <= filter_loaded_d;
        end
    end
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        filter_loaded_d = filter_loaded_q;
        case (state_q)
            IDLE:      if (start) state_d = skip ? LOAD_IMG : LOAD_FILT;
            LOAD_FILT,
            LOAD_IMG: begin
                if (beat) begin
                    col_d = col_wrap ? '0 : col_q + IDX_W'(1);
                    row_d = last ? '0 : col_wrap ? row_q + IDX_W'(1) : row_q;
                    if (last) begin
                        state_d         = state_q == LOAD_FILT ? LOAD_IMG : HOLD;
                        filter_loaded_d = filter_loaded_q || state_q == LOAD_FILT;
                    end
                end
            end
            HOLD:      if (tile_ack) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end
    tile_bank #(.ELEMS(TILE_ELEMS), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_filter_bank (
        .clk(clk), .rst(rst), .we(beat && state_q == LOAD_FILT),
        .idx(idx), .wdata(s_data), .flat(filter_flat)
    );
    tile_bank #(.ELEMS(TILE_ELEMS), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_img_bank (
        .clk(clk), .rst(rst), .we(beat && state_q == LOAD_IMG),
        .idx(idx), .wdata(s_data), .flat(img_flat)
    );
endmodule

// File: doc/conv_tile_writer.md
CONV_TILE_WRITER -- requirements
Module: conv_tile_writer

Interface
REQ-001 Parameter ROWS, default 3: tile rows.
REQ-002 Parameter COLS, default 3: tile columns.
REQ-003 Parameter DATA_W, default 8: element width, unsigned.
REQ-004 Port clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: single-cycle request to begin one tile load.
REQ-007 Port load_filter  input  1: sampled with start; requests a filter reload (see REQ-024).
REQ-008 Port s_data  input  DATA_W: stream element.
REQ-009 Port s_valid  input  1: s_data valid.
REQ-010 Port s_ready  output  1: block accepts s_data.
REQ-011 Port filter_flat  output  ROWS*COLS*DATA_W: filter bank; element [r][c] at bits (r*COLS+c)*DATA_W +: DATA_W.
REQ-012 Port img_flat  output  ROWS*COLS*DATA_W: image bank; same packing as filter_flat.
REQ-013 Port tile_valid  output  1: both banks complete and stable for the consumer.
REQ-014 Port tile_ack  input  1: consumer has taken the tile.
REQ-015 Port busy  output  1: high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, LOAD_FILT, LOAD_IMG, HOLD.
REQ-017 IDLE: s_ready=0, tile_valid=0; start=1 moves to LOAD_FILT, or to LOAD_IMG when the filter load is skipped (REQ-024).
REQ-018 LOAD_FILT/LOAD_IMG: s_ready=1; a beat transfers only when s_valid&&s_ready; s_valid gaps stall without side effects.
REQ-019 Each beat writes the current bank at index {row,col}, row-major; col increments and wraps from COLS-1 to 0 with row+1.
REQ-020 Beat at index ROWS*COLS-1: LOAD_FILT goes to LOAD_IMG, LOAD_IMG goes to HOLD; row and col clear to 0 in the same cycle.
REQ-021 tile_valid rises in the cycle after the last image beat is accepted (latency 1); s_ready is 0 in that cycle.
REQ-022 HOLD: tile_valid=1, s_ready=0, both buses frozen; tile_ack=1 moves to IDLE, and tile_valid is 0 from the next cycle.
REQ-023 start outside IDLE and tile_ack outside HOLD are ignored; start and tile_ack together in HOLD: ack is honoured, start is dropped.
REQ-024 filter_loaded flag is set on completion of LOAD_FILT; the filter skip decision follows Configuration.
REQ-025 Banks are written only by accepted beats; no arithmetic on data. Index counters are $clog2(ROWS*COLS) bits wide.

Reset
REQ-026 rst=1: state IDLE, s_ready=0, tile_valid=0, busy=0, filter_flat=0, img_flat=0, row=col=0, filter_loaded=0.
REQ-027 rst during LOAD_* or HOLD aborts the tile, discards all partial data and takes effect on the same edge.

Configuration
REQ-028 Macro CONV_TILE_FILTER_REUSE_EN defined: when start=1 with load_filter=0 and filter_loaded=1, LOAD_FILT is skipped and the filter bank is retained; otherwise LOAD_FILT runs.
REQ-029 Macro not defined: load_filter is ignored; every tile runs LOAD_FILT; filter_loaded has no functional effect.

Structure
REQ-030 Package conv_pkg holds ROWS, COLS, DATA_W, ELEMS=ROWS*COLS and the FSM state typedef; it is shared with the convolution datapath.
REQ-031 Sub-module tile_bank (ELEMS x DATA_W register bank: we, index, wdata, flat output, synchronous clear) is instantiated twice, once for filter and once for image.

Verification
REQ-032 Stream 0x01..0x09 then 0x11..0x19 continuously after start -> filter_flat[7:0]=0x01, filter_flat[71:64]=0x09, img_flat[71:64]=0x19; tile_valid rises one cycle after beat 18.
REQ-033 Insert random s_valid gaps of 0-5 cycles -> bank contents are the same as in REQ-032; no write occurs while s_valid=0.
REQ-034 Hold tile_ack=0 for 20 cycles in HOLD while driving s_valid=1 -> s_ready=0 throughout, buses unchanged; ack -> IDLE next cycle.
REQ-035 Assert rst after beat 12 -> all outputs 0 on the next cycle; a fresh start then loads from index 0 of the filter.
REQ-036 With CONV_TILE_FILTER_REUSE_EN: second start with load_filter=0 -> 9 beats go to img_flat only and filter_flat is unchanged; without the macro -> 18 beats are required.
REQ-037 Pulse start during LOAD_IMG, and tile_ack during LOAD_FILT -> no state change, no counter disturbance.
